fp_mul_arbiter: RTL
===================

Name: fp_mul_arbiter

Overview:
- Shares one combinational fp_mul instance between NUM_REQ requesters.
- Each requester submits a 64-bit operand pair over a valid/ready handshake. The block grants one requester at a time in round-robin order, registers the operands into fp_mul and holds the operation for LATENCY cycles (multicycle timing budget for the 53x53 multiplier path).
- It returns the registered product with the requester id over a valid/ready response channel.
- Sits between the calculator's operation dispatch and the single fp_mul datapath.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- LATENCY, 2, cycles the operands are held stable before the product is captured; legal range 1..8.
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand-pair valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high in any cycle.
- req_a  input  NUM_REQ*64  operand A of requester i at bits [64*i+63:64*i].
- req_b  input  NUM_REQ*64  operand B of requester i, same packing.
- resp_valid  output  1  result valid.
- resp_ready  input  1  result consumer accept.
- resp_data  output  64  IEEE 754 double product from fp_mul.
- resp_id  output  ID_W  index of the requester owning resp_data.
- busy  output  1  high in any state other than IDLE.
- stat_ops  output  32  completed-operation counter (optional feature).
- stat_nan  output  32  NaN-result counter (optional feature).

Behaviour:
- Reset (rst high at an edge): state=IDLE, rr_ptr=0, cnt=0, operand registers=0, resp_data=0, resp_id=0. All outputs low. An operation in flight is abandoned and no response is produced.
- Arbitration is round-robin. Search starts at rr_ptr, wrapping modulo NUM_REQ; the first i with req_valid[i]=1 wins.
- IDLE:
  - req_ready[g]=1 combinationally for the winner g only, and only in IDLE.
  - On an edge with req_valid[g]&&req_ready[g]: latch req_a/req_b slice g into op_a/op_b, latch resp_id=g, set rr_ptr=(g+1) mod NUM_REQ, cnt=LATENCY-1, go EXEC.
  - No requester valid: stay in IDLE; rr_ptr unchanged.
- EXEC:
  - op_a/op_b drive fp_mul and stay constant.
  - cnt!=0: cnt decrements.
  - cnt==0: resp_data captures fp_mul output, go RESP.
  - req_ready is all zero throughout EXEC.
- RESP:
  - resp_valid=1; resp_data and resp_id stay stable until the handshake.
  - resp_valid&&resp_ready at an edge: go IDLE. No grant is issued in the same cycle.
- Timing:
  - Accept at edge k means resp_valid is high from edge k+LATENCY.
  - Minimum issue interval is LATENCY+2 cycles.
- Requester rules:
  - A requester must keep req_valid and its operands stable until accepted; the arbiter does not sample unaccepted data.
  - A requester that drops req_valid before grant is simply skipped.
- busy = (state!=IDLE).
- Special values (NaN, Inf, zero, 0*Inf) are passed through from fp_mul unmodified. The canonical NaN is 0x7FF8000000000001.

Optional Feature:
- Macro: FP_MUL_ARB_STATS_EN.
- When defined:
  - stat_ops increments by 1 on each response handshake.
  - stat_nan increments when resp_data[62:52]==11'h7FF and resp_data[51:0]!=0 at that handshake.
  - Both counters wrap at 2^32 and clear on rst.
- When undefined: stat_ops and stat_nan are tied to 0 and no counter flops exist. The port list is identical in both builds.

Test Plan:
- Basic multiply: req0 A=0x4000000000000000 (2.0), B=0x4008000000000000 (3.0), LATENCY=2, resp_ready=1.
  -> resp_data=0x4018000000000000, resp_id=0, resp_valid 2 cycles after accept.
- Round robin: all four req_valid held high with distinct operands, resp_ready=1.
  -> grant order 0,1,2,3,0; each resp_id matches its grant; issues spaced exactly 4 cycles apart.
- Special case: A=0x0000000000000000, B=0x7FF0000000000000 (0*Inf).
  -> resp_data=0x7FF8000000000001.
  -> With FP_MUL_ARB_STATS_EN: stat_nan=1, stat_ops=1.
- Backpressure: resp_ready low for 5 cycles while RESP, req1 valid throughout.
  -> resp_data/resp_id stable; req_ready stays 0.
  -> req1 accepted 1 cycle after the response handshake.
- Reset mid-operation: assert rst for one cycle during EXEC.
  -> no resp_valid afterwards; busy=0; rr_ptr=0, so req0 wins the next arbitration over req2 when both are valid.
- Sign/rounding: A=0xBFF0000000000001, B=0x4000000000000000.
  -> resp_data=0xC000000000000001, resp_id equals the issuing requester.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one combinational double-precision multiplier
// Define FP_MUL_ARB_STATS_EN to enable the stat_ops/stat_nan counters.

module fp_mul (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] p
);
    logic               sa, sb, s;
    logic [10:0]        ea, eb, xa, xb, ef;
    logic [51:0]        fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [52:0]        ma, mb;
    logic [105:0]       prod, norm, shifted, lost_mask;
    logic [6:0]         lz;
    logic signed [12:0] en;
    logic [12:0]        sh;
    logic               guard, sticky;
    logic [62:0]        mag;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign s      = sa ^ sb;
    assign a_nan  = (ea == 11'h7FF) && (fa != '0);
    assign b_nan  = (eb == 11'h7FF) && (fb != '0);
    assign a_inf  = (ea == 11'h7FF) && (fa == '0);
    assign b_inf  = (eb == 11'h7FF) && (fb == '0);
    assign a_zero = (ea == '0) && (fa == '0);
    assign b_zero = (eb == '0) && (fb == '0);

    always_comb begin
        ma   = {ea != '0, fa};
        mb   = {eb != '0, fb};
        xa   = (ea == '0) ? 11'd1 : ea;
        xb   = (eb == '0) ? 11'd1 : eb;
        prod = 106'(ma) * 106'(mb);
        lz   = 7'd106;
        for (int i = 0; i < 106; i++) begin
            if (prod[i]) lz = 7'(105 - i);
        end
        norm = prod << lz;
        // Biased exponent of the normalised product with the leading one at bit 105.
        en = $signed({2'b00, xa}) + $signed({2'b00, xb}) - 13'sd1022 - $signed({6'b0, lz});
        sh = (en >= 13'sd1) ? 13'd0 : 13'(13'sd1 - en);
        shifted   = norm >> sh;
        lost_mask = ~({106{1'b1}} << sh);
        guard     = shifted[52];
        sticky    = (|shifted[51:0]) | (|(norm & lost_mask));
        ef        = (en >= 13'sd1) ? en[10:0] : {10'b0, shifted[105]};
        // Carry out of the fraction rolls into the exponent (subnormal->normal, max->Inf).
        mag = {ef, shifted[104:53]} + 63'(guard & (sticky | shifted[53]));
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
            p = 64'h7FF8_0000_0000_0001;
        else if (a_inf || b_inf)
            p = {s, 11'h7FF, 52'b0};
        else if (a_zero || b_zero)
            p = {s, 63'b0};
        else if (en >= 13'sd2047)
            p = {s, 11'h7FF, 52'b0};
        else
            p = {s, mag};
    end
endmodule

module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_a,
    input  logic [NUM_REQ*64-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [63:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    output logic                  busy,
    output logic [31:0]           stat_ops,
    output logic [31:0]           stat_nan
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW    = ID_W + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr, win;
    logic [SW-1:0]   cand;
    logic            found;
    logic [CNT_W-1:0] cnt;
    logic [63:0]     op_a, op_b, prod;

    fp_mul u_fp_mul (.a(op_a), .b(op_b), .p(prod));

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + SW'(k);
            if (cand >= SW'(NUM_REQ)) cand = cand - SW'(NUM_REQ);
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                win   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found && !rst) req_ready[win] = 1'b1;
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            resp_data <= '0;
            resp_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a    <= req_a[64*win +: 64];
                        op_b    <= req_b[64*win +: 64];
                        resp_id <= win;
                        rr_ptr  <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_data <= prod;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FP_MUL_ARB_STATS_EN
    logic [31:0] ops_q, nan_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q <= '0;
            nan_q <= '0;
        end else if (resp_valid && resp_ready) begin
            ops_q <= ops_q + 32'd1;
            if (resp_data[62:52] == 11'h7FF && resp_data[51:0] != '0) nan_q <= nan_q + 32'd1;
        end
    end

    assign stat_ops = ops_q;
    assign stat_nan = nan_q;
`else
    assign stat_ops = '0;
    assign stat_nan = '0;
`endif
endmodule
